// File: rtl/eram_if_responder.sv
// ----------------------------------------------------------------------------
// eram_if_responder
//
// Responder on the external-memory side. It terminates the token stream that
// the tile-side interface sends toward ERAM. A request is an acquire token
// followed by four header words: T-ID, F-ID, attribute and base address.
//   * Store: each following word, including the terminating release word, is
//     written to consecutive BRAM addresses starting at the base.
//   * Load : Length words are read from BRAM. They are returned as a token
//     stream that opens with an acquire word and whose last word is a
//     release word. Back-pressure from I_BTk (nack) is honoured.
//
// Token layout (FTk, MSB first): {v, a, r, i[WIDTH_ID-1:0], d[WIDTH_DATA-1:0]}
// Back token (BTk): a single bit, n = nack.
// Attribute word: bit WIDTH_DATA-1 = is_Pull (load), bits [15:0] = Length.
//
// Ports:
//   clock    - the only clock
//   reset    - asynchronous, active-high reset
//   I_FTk    - request/store stream from the tile interface
//   O_BTk    - nack toward the tile interface
//   O_FTk    - load-response stream toward the tile interface
//   I_BTk    - nack for the response stream
//   O_Addr   - BRAM word address
//   O_We     - BRAM write enable
//   O_Re     - BRAM read enable
//   O_WData  - BRAM write data
//   I_RData  - BRAM read data, valid RD_LATENCY cycles after O_Re
//   O_Busy   - high whenever the FSM is outside IDLE
//
// Optional feature, macro ERAM_RSP_ID_ECHO_EN:
//   When it is defined, the load acquire word carries d = F-ID and
//   i = T-ID of the request. When it is undefined, both fields are 0 and
//   the ID registers are not built.
// ----------------------------------------------------------------------------
module eram_if_responder #(
    parameter int WIDTH_ADDR = 12,
    parameter int RD_LATENCY = 1,
    parameter int DEPTH_SKID = 2,
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_ID   = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [WIDTH_DATA+WIDTH_ID+2:0]     I_FTk,
    output logic                               O_BTk,
    output logic [WIDTH_DATA+WIDTH_ID+2:0]     O_FTk,
    input  logic                               I_BTk,
    output logic [WIDTH_ADDR-1:0]              O_Addr,
    output logic                               O_We,
    output logic                               O_Re,
    output logic [WIDTH_DATA-1:0]              O_WData,
    input  logic [WIDTH_DATA-1:0]              I_RData,
    output logic                               O_Busy
);

    localparam int FTK_W = WIDTH_DATA + WIDTH_ID + 3;
    localparam int V_BIT = FTK_W - 1;
    localparam int A_BIT = FTK_W - 2;
    localparam int R_BIT = FTK_W - 3;
    localparam int EW    = WIDTH_DATA + 2;                       // skid entry {a, r, d}
    localparam int PW    = (DEPTH_SKID > 1) ? $clog2(DEPTH_SKID) : 1;
    localparam int CW    = $clog2(DEPTH_SKID + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH_SKID);

    if (RD_LATENCY != 1) begin : g_rd_latency_check
        $error("eram_if_responder: only RD_LATENCY == 1 is supported");
    end

    typedef enum logic [2:0] {
        IDLE,
        HDR_TID,
        HDR_FID,
        HDR_ATTR,
        HDR_ADDR,
        ST_RUN,
        LD_ACQ,
        LD_RUN
    } state_t;

    typedef struct packed {
        logic        is_Pull;
        logic [15:0] O_Length;
    } attr_t;

    function automatic attr_t AttributeDec(input logic [WIDTH_DATA-1:0] attr);
        attr_t res;
        res.is_Pull  = attr[WIDTH_DATA-1];
        res.O_Length = attr[15:0];
        return res;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH_SKID - 1)) ? '0 : p + 1'b1;
    endfunction

    // Input token fields
    logic                  in_v, in_a, in_r, in_acq, in_rel;
    logic [WIDTH_DATA-1:0] in_d;
    attr_t                 attr_dec;
    logic                  unused_ftk;

    assign in_v       = I_FTk[V_BIT];
    assign in_a       = I_FTk[A_BIT];
    assign in_r       = I_FTk[R_BIT];
    assign in_d       = I_FTk[WIDTH_DATA-1:0];
    assign in_acq     = in_v & in_a & ~in_r;
    assign in_rel     = in_v & in_a & in_r;
    assign attr_dec   = AttributeDec(in_d);
    assign unused_ftk = ^I_FTk;

    // State
    state_t                state_q, state_d;
    logic                  pull_q, pull_d;
    logic [15:0]           len_q, len_d;
    logic [WIDTH_ADDR-1:0] ptr_q, ptr_d;          // base + k
    logic [15:0]           rd_cnt_q, rd_cnt_d;    // reads issued
    logic                  we_q, we_d;
    logic [WIDTH_ADDR-1:0] waddr_q, waddr_d;
    logic [WIDTH_DATA-1:0] wdata_q, wdata_d;
    logic                  rvalid_q, rvalid_d;    // read data arrives this cycle
    logic                  rlast_q, rlast_d;      // ... and it is the last word
    logic [EW-1:0]         mem_q [DEPTH_SKID];
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;

`ifdef ERAM_RSP_ID_ECHO_EN
    logic [WIDTH_ID-1:0]   tid_q, tid_d;
    logic [WIDTH_DATA-1:0] fid_q, fid_d;
`endif

    // Combinational control
    logic                  nack, take, out_v, pop, re, push;
    logic [EW-1:0]         head, push_word;
    logic [CW:0]           occ;
    logic [WIDTH_DATA-1:0] acq_d;
    logic [WIDTH_ID-1:0]   acq_i;

    assign head  = mem_q[rp_q];
    assign out_v = (cnt_q != '0);
    assign pop   = out_v & ~I_BTk;
    // Reads in flight plus entries already buffered; the skid buffer must be
    // able to hold every issued read if the consumer stalls indefinitely.
    assign occ   = {1'b0, cnt_q} + {{CW{1'b0}}, rvalid_q};

`ifdef ERAM_RSP_ID_ECHO_EN
    assign acq_d = fid_q;
    assign acq_i = tid_q;
`else
    assign acq_d = '0;
    assign acq_i = '0;
`endif

    always_comb begin
        state_d   = state_q;
        pull_d    = pull_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        rd_cnt_d  = rd_cnt_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        push      = 1'b0;
        push_word = '0;
`ifdef ERAM_RSP_ID_ECHO_EN
        tid_d     = tid_q;
        fid_d     = fid_q;
`endif

        nack = (state_q == LD_ACQ) || (state_q == LD_RUN) ||
               ((state_q != IDLE) && in_acq);
        take = in_v & ~nack;
        re   = (state_q == LD_RUN) && (rd_cnt_q != len_q) && (occ < DEPTH_L);

        rvalid_d = re;
        rlast_d  = re && ((rd_cnt_q + 16'd1) == len_q);

        case (state_q)
            IDLE: begin
                if (take && in_acq) begin
                    state_d = HDR_TID;
                end
            end
            HDR_TID: begin
                if (take) begin
`ifdef ERAM_RSP_ID_ECHO_EN
                    tid_d = in_d[WIDTH_ID-1:0];
`endif
                    state_d = HDR_FID;
                end
            end
            HDR_FID: begin
                if (take) begin
`ifdef ERAM_RSP_ID_ECHO_EN
                    fid_d = in_d;
`endif
                    state_d = HDR_ATTR;
                end
            end
            HDR_ATTR: begin
                if (take) begin
                    pull_d  = attr_dec.is_Pull;
                    len_d   = attr_dec.O_Length;
                    state_d = HDR_ADDR;
                end
            end
            HDR_ADDR: begin
                if (take) begin
                    ptr_d    = in_d[WIDTH_ADDR-1:0];
                    rd_cnt_d = '0;
                    if (pull_q) begin
                        // The skid buffer is empty here; the acquire word is
                        // queued through it like any other response word.
                        push      = 1'b1;
                        push_word = {1'b1, 1'b0, acq_d};
                        state_d   = LD_ACQ;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (take) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q;
                    wdata_d = in_d;
                    ptr_d   = ptr_q + 1'b1;
                    if (in_rel) begin
                        state_d = IDLE;
                    end
                end
            end
            LD_ACQ: begin
                if (pop) begin
                    if (len_q == '0) begin
                        push      = 1'b1;
                        push_word = {1'b1, 1'b1, {WIDTH_DATA{1'b0}}};
                    end
                    state_d = LD_RUN;
                end
            end
            LD_RUN: begin
                if (pop && head[EW-2]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (re) begin
            ptr_d    = ptr_q + 1'b1;
            rd_cnt_d = rd_cnt_q + 16'd1;
        end

        if (rvalid_q) begin
            push      = 1'b1;
            push_word = {rlast_q, rlast_q, I_RData};
        end

        wp_d  = push ? ptr_next(wp_q) : wp_q;
        rp_d  = pop ? ptr_next(rp_q) : rp_q;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pull_q   <= 1'b0;
            len_q    <= '0;
            ptr_q    <= '0;
            rd_cnt_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            for (int unsigned k = 0; k < DEPTH_SKID; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pull_q   <= pull_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
            rd_cnt_q <= rd_cnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wp_q] <= push_word;
            end
        end
    end

`ifdef ERAM_RSP_ID_ECHO_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tid_q <= '0;
            fid_q <= '0;
        end else begin
            tid_q <= tid_d;
            fid_q <= fid_d;
        end
    end
`endif

    // Outputs
    assign O_BTk   = nack;
    assign O_Busy  = (state_q != IDLE);
    assign O_We    = we_q;
    assign O_Re    = re;
    assign O_WData = wdata_q;
    // Writes come from the store path and reads from the load path. A store's
    // final write can be pending while the FSM is already IDLE, but it never
    // coincides with a read.
    assign O_Addr  = we_q ? waddr_q : (re ? ptr_q : '0);
    assign O_FTk   = {out_v,
                      out_v & head[EW-1],
                      out_v & head[EW-2],
                      (out_v & head[EW-1] & ~head[EW-2]) ? acq_i : {WIDTH_ID{1'b0}},
                      out_v ? head[WIDTH_DATA-1:0] : {WIDTH_DATA{1'b0}}};

endmodule

// File: tb/tb_eram_if_responder.sv
module tb_eram_if_responder;

    localparam int WA = 12;
    localparam int WD = 32;
    localparam int WI = 8;
    localparam int WF = WD + WI + 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [WF-1:0] I_FTk;
    logic          O_BTk;
    logic [WF-1:0] O_FTk;
    logic          I_BTk;
    logic [WA-1:0] O_Addr;
    logic          O_We;
    logic          O_Re;
    logic [WD-1:0] O_WData;
    logic [WD-1:0] I_RData;
    logic          O_Busy;

    int n_checks = 0;
    int n_fail   = 0;

    eram_if_responder #(
        .WIDTH_ADDR (WA),
        .RD_LATENCY (1),
        .DEPTH_SKID (2),
        .WIDTH_DATA (WD),
        .WIDTH_ID   (WI)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .I_FTk   (I_FTk),
        .O_BTk   (O_BTk),
        .O_FTk   (O_FTk),
        .I_BTk   (I_BTk),
        .O_Addr  (O_Addr),
        .O_We    (O_We),
        .O_Re    (O_Re),
        .O_WData (O_WData),
        .I_RData (I_RData),
        .O_Busy  (O_Busy)
    );

    always #5 clock = ~clock;

    // BRAM model, read latency 1
    logic [WD-1:0] bram [0:(1<<WA)-1];
    always @(posedge clock) begin
        if (O_We) bram[O_Addr] <= O_WData;
        if (O_Re) I_RData <= bram[O_Addr];
    end

    // Observed writes and read count
    logic [WA+WD-1:0] wlog[$];
    int               re_cnt = 0;
    always @(posedge clock) begin
        if (O_We) wlog.push_back({O_Addr, O_WData});
        if (O_Re) re_cnt++;
    end

    // Received response words
    logic [WF-1:0] rx[$];
    int            rx_timeout;
    int            rx_latency;
    int            rx_max_out;

    function automatic logic [WF-1:0] tk(input logic v, input logic a, input logic r,
                                          input logic [WI-1:0] i, input logic [WD-1:0] d);
        return {v, a, r, i, d};
    endfunction

    function automatic logic [WF-1:0] acq_exp(input logic [WI-1:0] tid, input logic [WD-1:0] fid);
`ifdef ERAM_RSP_ID_ECHO_EN
        return tk(1'b1, 1'b1, 1'b0, tid, fid);
`else
        return tk(1'b1, 1'b1, 1'b0, '0, '0);
`endif
    endfunction

    function automatic logic [WF-1:0] rx_at(input int k);
        return (rx.size() > k) ? rx[k] : '0;
    endfunction

    function automatic logic [WA+WD-1:0] wlog_at(input int k);
        return (wlog.size() > k) ? wlog[k] : '0;
    endfunction

    task automatic send(input logic [WF-1:0] w);
        @(negedge clock);
        I_FTk = w;
    endtask

    task automatic send_hdr(input logic [WD-1:0] tid, input logic [WD-1:0] fid,
                            input logic [WD-1:0] attr, input logic [WD-1:0] addr);
        send(tk(1'b1, 1'b1, 1'b0, '0, '0));
        send(tk(1'b1, 1'b0, 1'b0, '0, tid));
        send(tk(1'b1, 1'b0, 1'b0, '0, fid));
        send(tk(1'b1, 1'b0, 1'b0, '0, attr));
        send(tk(1'b1, 1'b0, 1'b0, '0, addr));
    endtask

    // Consume response words until a release word (stop_after == 0) or until
    // stop_after words have been taken. With stall_en, every second word is
    // held off by nack for 3 cycles.
    task automatic collect(input bit stall_en, input int stop_after);
        int budget = 200;
        int stall = 0;
        int stalled_for = -1;
        int issued = 0;
        int cyc = 0;
        int acq_cyc = 0;
        int outst;
        rx.delete();
        rx_timeout = 1;
        rx_latency = 0;
        rx_max_out = 0;
        while (budget > 0) begin
            @(negedge clock);
            I_FTk = '0;
            budget--;
            cyc++;
            if (stall_en && O_FTk[WF-1] && (rx.size() % 2 == 1) && stalled_for != rx.size()) begin
                stall = 3;
                stalled_for = rx.size();
            end
            I_BTk = (stall > 0);
            if (stall > 0) stall--;
            #1;
            if (O_Re) issued++;
            if (O_FTk[WF-1] && !I_BTk) begin
                rx.push_back(O_FTk);
                if (rx.size() == 1) acq_cyc = cyc;
                if (rx.size() == 2) rx_latency = cyc - acq_cyc;
            end
            outst = issued - ((rx.size() > 0) ? rx.size() - 1 : 0);
            if (outst > rx_max_out) rx_max_out = outst;
            if ((stop_after != 0 && rx.size() >= stop_after) ||
                (stop_after == 0 && rx.size() >= 2 && rx[rx.size()-1][WF-2] && rx[rx.size()-1][WF-3])) begin
                rx_timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        I_FTk = '0;
        I_BTk = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (O_FTk !== '0) begin n_fail++; $display("FAIL reset_ftk: got %h expected 0", O_FTk); end
        n_checks++;
        if ({O_BTk, O_Busy} !== 2'b00) begin n_fail++; $display("FAIL reset_btk_busy: got %b expected 00", {O_BTk, O_Busy}); end
        n_checks++;
        if ({O_We, O_Re, O_Addr, O_WData} !== '0) begin
            n_fail++; $display("FAIL reset_bram: got we=%b re=%b addr=%h wdata=%h expected all 0", O_We, O_Re, O_Addr, O_WData);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (O_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b expected 0", O_Busy); end
    endtask

    task automatic test_store();
        int b = wlog.size();
        logic [WA+WD-1:0] exp_w [4] = '{{12'h010, 32'hA}, {12'h011, 32'hB}, {12'h012, 32'hC}, {12'h013, 32'hD}};
        send_hdr(32'd3, 32'd5, 32'h0000_0004, 32'h010);
        send(tk(1'b1, 1'b0, 1'b0, '0, 32'hA));
        send(tk(1'b1, 1'b0, 1'b0, '0, 32'hB));
        send(tk(1'b1, 1'b0, 1'b0, '0, 32'hC));
        send(tk(1'b1, 1'b1, 1'b1, '0, 32'hD));
        #1;
        n_checks++;
        if (O_Busy !== 1'b1) begin n_fail++; $display("FAIL store_busy_during: got %b expected 1", O_Busy); end
        @(posedge clock);
        #1;
        n_checks++;
        if ({O_We, O_Addr, O_WData} !== {1'b1, 12'h013, 32'hD}) begin
            n_fail++; $display("FAIL store_release_write: got we=%b addr=%h data=%h expected 1/013/d", O_We, O_Addr, O_WData);
        end
        n_checks++;
        if (O_Busy !== 1'b0) begin n_fail++; $display("FAIL store_busy_after: got %b expected 0", O_Busy); end
        @(negedge clock);
        I_FTk = '0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (wlog.size() !== b + 4) begin n_fail++; $display("FAIL store_count: got %0d expected %0d", wlog.size() - b, 4); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wlog_at(b + k) !== exp_w[k]) begin
                n_fail++; $display("FAIL store_write%0d: got %h expected %h", k, wlog_at(b + k), exp_w[k]);
            end
        end
    endtask

    task automatic test_load(input bit stall_en);
        logic [WF-1:0] exp_r [5];
        exp_r[0] = acq_exp(8'd3, 32'd5);
        exp_r[1] = tk(1'b1, 1'b0, 1'b0, '0, 32'hA);
        exp_r[2] = tk(1'b1, 1'b0, 1'b0, '0, 32'hB);
        exp_r[3] = tk(1'b1, 1'b0, 1'b0, '0, 32'hC);
        exp_r[4] = tk(1'b1, 1'b1, 1'b1, '0, 32'hD);
        send_hdr(32'd3, 32'd5, 32'h8000_0004, 32'h010);
        collect(stall_en, 0);
        n_checks++;
        if (rx_timeout != 0) begin n_fail++; $display("FAIL load_timeout: got no release within budget, expected release (stall=%0d)", stall_en); end
        n_checks++;
        if (rx.size() != 5) begin n_fail++; $display("FAIL load_count: got %0d expected 5 (stall=%0d)", rx.size(), stall_en); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (rx_at(k) !== exp_r[k]) begin
                n_fail++; $display("FAIL load_word%0d: got %h expected %h (stall=%0d)", k, rx_at(k), exp_r[k], stall_en);
            end
        end
        n_checks++;
        if (rx_latency < 2) begin n_fail++; $display("FAIL load_latency: got %0d cycles expected >= 2", rx_latency); end
        n_checks++;
        if (rx_max_out > 2) begin n_fail++; $display("FAIL load_skid: got %0d outstanding expected <= 2", rx_max_out); end
        I_BTk = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({O_Busy, O_FTk[WF-1]} !== 2'b00) begin n_fail++; $display("FAIL load_idle: got busy/v=%b expected 00", {O_Busy, O_FTk[WF-1]}); end
    endtask

    task automatic test_wrap();
        int b = wlog.size();
        logic [WA+WD-1:0] exp_w [3] = '{{12'hFFF, 32'h1}, {12'h000, 32'h2}, {12'h001, 32'h3}};
        send_hdr(32'd1, 32'd2, 32'h0000_0003, 32'hFFF);
        send(tk(1'b1, 1'b0, 1'b0, '0, 32'h1));
        send(tk(1'b1, 1'b1, 1'b0, '0, 32'h0));
        #1;
        n_checks++;
        if (O_BTk !== 1'b1) begin n_fail++; $display("FAIL wrap_unexp_acq_nack: got %b expected 1", O_BTk); end
        send(tk(1'b1, 1'b0, 1'b0, '0, 32'h2));
        send(tk(1'b1, 1'b1, 1'b1, '0, 32'h3));
        @(negedge clock);
        I_FTk = '0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (wlog.size() !== b + 3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", wlog.size() - b); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (wlog_at(b + k) !== exp_w[k]) begin
                n_fail++; $display("FAIL wrap_write%0d: got %h expected %h", k, wlog_at(b + k), exp_w[k]);
            end
        end
    endtask

    task automatic test_len0();
        int r0 = re_cnt;
        send_hdr(32'd7, 32'd9, 32'h8000_0000, 32'h123);
        collect(1'b0, 0);
        n_checks++;
        if (rx_timeout != 0) begin n_fail++; $display("FAIL len0_timeout: got no release, expected release"); end
        n_checks++;
        if (rx.size() != 2) begin n_fail++; $display("FAIL len0_count: got %0d expected 2", rx.size()); end
        n_checks++;
        if (rx_at(0) !== acq_exp(8'd7, 32'd9)) begin n_fail++; $display("FAIL len0_acq: got %h expected %h", rx_at(0), acq_exp(8'd7, 32'd9)); end
        n_checks++;
        if (rx_at(1) !== tk(1'b1, 1'b1, 1'b1, '0, '0)) begin
            n_fail++; $display("FAIL len0_release: got %h expected %h", rx_at(1), tk(1'b1, 1'b1, 1'b1, '0, '0));
        end
        @(negedge clock);
        n_checks++;
        if (re_cnt != r0) begin n_fail++; $display("FAIL len0_no_read: got %0d reads expected 0", re_cnt - r0); end
    endtask

    task automatic test_reset_midload();
        int b;
        int seen_v = 0;
        logic [WF-1:0] exp_r [4];
        send_hdr(32'd3, 32'd5, 32'h8000_0004, 32'h010);
        collect(1'b0, 3);
        n_checks++;
        if (rx_timeout != 0) begin n_fail++; $display("FAIL midload_progress: got %0d words expected 3", rx.size()); end
        @(negedge clock);
        I_BTk = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({O_FTk, O_BTk, O_Busy} !== '0) begin
            n_fail++; $display("FAIL midload_reset_stream: got ftk=%h btk=%b busy=%b expected all 0", O_FTk, O_BTk, O_Busy);
        end
        n_checks++;
        if ({O_We, O_Re, O_Addr, O_WData} !== '0) begin
            n_fail++; $display("FAIL midload_reset_bram: got we=%b re=%b addr=%h wdata=%h expected all 0", O_We, O_Re, O_Addr, O_WData);
        end
        @(negedge clock);
        reset = 1'b0;
        I_BTk = 1'b0;
        repeat (4) begin
            @(negedge clock);
            #1;
            if (O_FTk[WF-1]) seen_v++;
        end
        n_checks++;
        if (seen_v != 0) begin n_fail++; $display("FAIL midload_no_release: got %0d valid words expected 0", seen_v); end

        b = wlog.size();
        send_hdr(32'd4, 32'd6, 32'h0000_0003, 32'h020);
        send(tk(1'b1, 1'b0, 1'b0, '0, 32'h11));
        send(tk(1'b1, 1'b0, 1'b0, '0, 32'h22));
        send(tk(1'b1, 1'b1, 1'b1, '0, 32'h33));
        @(negedge clock);
        I_FTk = '0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({wlog_at(b), wlog_at(b + 1), wlog_at(b + 2)} !== {12'h020, 32'h11, 12'h021, 32'h22, 12'h022, 32'h33}) begin
            n_fail++; $display("FAIL post_reset_store: got %h %h %h expected 020/11 021/22 022/33", wlog_at(b), wlog_at(b + 1), wlog_at(b + 2));
        end

        exp_r[0] = acq_exp(8'd4, 32'd6);
        exp_r[1] = tk(1'b1, 1'b0, 1'b0, '0, 32'h11);
        exp_r[2] = tk(1'b1, 1'b0, 1'b0, '0, 32'h22);
        exp_r[3] = tk(1'b1, 1'b1, 1'b1, '0, 32'h33);
        send_hdr(32'd4, 32'd6, 32'h8000_0003, 32'h020);
        collect(1'b1, 0);
        n_checks++;
        if (rx.size() != 4) begin n_fail++; $display("FAIL post_reset_load_count: got %0d expected 4", rx.size()); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rx_at(k) !== exp_r[k]) begin
                n_fail++; $display("FAIL post_reset_load_word%0d: got %h expected %h", k, rx_at(k), exp_r[k]);
            end
        end
        I_BTk = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store();
        test_load(1'b0);
        test_load(1'b1);
        test_wrap();
        test_len0();
        test_reset_midload();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

endmodule
